// File: rtl/arb_pkg.sv
// Shared encodings and helpers for the 8-requester arbiter.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [CODE_W-1:0] lowest_idx(input logic [N_REQ-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick_8_v.sv
// Combinational winner select: lowest request at or above the pointer in
// round-robin mode, otherwise (or on wrap) the lowest request overall.
module arb_pick_8_v
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0]  i_req,
  input  logic [CODE_W-1:0] i_ptr,
  input  logic              i_rr,
  output logic [CODE_W-1:0] o_code,
  output logic              o_v
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;

  always_comb begin
    mask   = {N_REQ{1'b1}} << i_ptr;
    masked = i_req & mask;
    o_v    = |i_req;
    if (i_rr && (|masked)) begin
      o_code = lowest_idx(masked);
    end else begin
      o_code = lowest_idx(i_req);
    end
  end

endmodule

// File: rtl/req_arbiter_8_v.sv
// 8-requester arbiter: grant is held until release, request drop or hold
// timeout, followed by a one-cycle GAP before the next arbitration.
module req_arbiter_8_v
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic [N_REQ-1:0]  i_req,
  input  logic              i_release,
  output logic [N_REQ-1:0]  o_grant,
  output logic [CODE_W-1:0] o_grant_code,
  output logic              o_grant_v,
  output logic              o_timeout,
  output logic [1:0]        o_state
);

  // Request/grant contract: a requester holds i_req[k] high for as long as it
  // wants the resource; it owns it while o_grant[k]=1 and hands it back by
  // pulsing i_release or by dropping i_req[k]. Requests are never latched.

  localparam bit TMO_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = TMO_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [HOLD_W-1:0] HOLD_SAT  = TMO_EN ? HOLD_W'(MAX_HOLD) : {HOLD_W{1'b1}};

  arb_state_e        state_q, state_d;
  logic [CODE_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              gv_q, gv_d;
  logic              tmo_q, tmo_d;

  logic [CODE_W-1:0] pick_code;
  logic              pick_v;
  logic              rel_exit;
  logic              tmo_hit;

  arb_pick_8_v u_pick (
    .i_req  (i_req),
    .i_ptr  (ptr_q),
    .i_rr   (i_mode),
    .o_code (pick_code),
    .o_v    (pick_v)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    code_d   = code_q;
    gv_d     = gv_q;
    tmo_d    = 1'b0;
    rel_exit = i_release | ~i_req[code_q];
    tmo_hit  = TMO_EN && (hold_q == HOLD_LAST);
    case (state_q)
      ST_IDLE: begin
        if (pick_v) begin
          grant_d = N_REQ'(1) << pick_code;
          code_d  = pick_code;
          gv_d    = 1'b1;
          hold_d  = '0;
          ptr_d   = pick_code + CODE_W'(1);
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (rel_exit || tmo_hit) begin
          // A timeout coinciding with release/drop is a normal handover.
          tmo_d   = tmo_hit & ~rel_exit;
          grant_d = '0;
          gv_d    = 1'b0;
          state_d = ST_GAP;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        gv_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      code_q  <= '0;
      gv_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      code_q  <= code_d;
      gv_q    <= gv_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_grant_code = code_q;
  assign o_grant_v    = gv_q;
  assign o_timeout    = tmo_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_req_arbiter_8_v.sv
// Randomized and directed bench for req_arbiter_8_v against a cycle-level
// reference model built from the arbitration rules.
module tb_req_arbiter_8_v;

  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 3;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;

  logic [7:0] o_grant;
  logic [2:0] o_grant_code;
  logic       o_grant_v;
  logic       o_timeout;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  req_arbiter_8_v #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mode       (mode),
    .i_req        (req),
    .i_release    (rel),
    .o_grant      (o_grant),
    .o_grant_code (o_grant_code),
    .o_grant_v    (o_grant_v),
    .o_timeout    (o_timeout),
    .o_state      (o_state)
  );

  // Scoreboard: expected {grant, code, grant_v, timeout}
  int n_checks = 0;
  int n_err    = 0;
  logic [12:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, how long, and the rotation start.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_code  = 0;
  bit m_tmo   = 1'b0;

  function automatic int winner(input logic [7:0] r, input bit rr, input int ptr);
    int start;
    start = rr ? ptr : 0;
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit dropped;
    bit expired;
    int w;
    logic [7:0] g;
    m_tmo = 1'b0;
    if (rst) begin
      m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_code = 0; m_held = 0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner < 0) begin
      w = winner(req, mode, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_code = w; m_ptr = (w + 1) % 8; m_held = 1;
      end
    end else begin
      dropped = rel || !req[m_owner];
      expired = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (dropped || expired) begin
        m_tmo   = expired && !dropped;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_held++;
      end
    end
    g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    exp_q.push_back({g, 3'(m_code), (m_owner >= 0), m_tmo});
  endtask

  // Driver: apply inputs, clock once, then compare on the falling edge.
  task automatic cycle(input bit r, input bit m, input logic [7:0] q, input bit rl);
    logic [12:0] e;
    rst = r; mode = m; req = q; rel = rl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("grant", o_grant, e[12:5]);
      check("code", o_grant_code, e[4:2]);
      check("grant_v", o_grant_v, e[1]);
      check("timeout", o_timeout, e[0]);
      check("v_eq_or", o_grant_v, |o_grant);
      check("onehot0", $onehot0(o_grant), 1);
    end
  endtask

  // Runs until a grant appears (bounded); code = -1 if none arrives.
  task automatic wait_grant(input bit m, input logic [7:0] q, output int code);
    code = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, m, q, 1'b0);
      if (o_grant_v) begin
        code = o_grant_code;
        break;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  int code;
  int exp_seq[$];
  logic [7:0] rq;
  bit rm;

  initial begin
    @(negedge clk);

    // Reset with all requests high, then first grant
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    check("rst_grant", o_grant, 8'h00);
    check("rst_state", o_state, 2'd0);
    cycle(1'b0, 1'b0, 8'hFF, 1'b0);
    check("t1_grant", o_grant, 8'h01);
    check("t1_code", o_grant_code, 3'd0);

    // Fixed priority re-grants the same winner after release
    do_reset();
    wait_grant(1'b0, 8'hA4, code);
    check("t2_first", code, 2);
    cycle(1'b0, 1'b0, 8'hA4, 1'b1);
    check("t2_gap_v", o_grant_v, 1'b0);
    check("t2_gap_code", o_grant_code, 3'd2);
    wait_grant(1'b0, 8'hA4, code);
    check("t2_again", code, 2);

    // Round-robin wrap between 0 and 7, then full rotation
    do_reset();
    exp_seq = '{0, 7, 0, 7};
    foreach (exp_seq[i]) begin
      wait_grant(1'b1, 8'h81, code);
      check("t3_wrap", code, exp_seq[i]);
      cycle(1'b0, 1'b1, 8'h81, 1'b1);
    end
    for (int i = 0; i < 9; i++) begin
      wait_grant(1'b1, 8'hFF, code);
      check("t3_rot", code, i % 8);
      cycle(1'b0, 1'b1, 8'hFF, 1'b1);
    end

    // Hold timeout passes ownership to the other requester
    do_reset();
    wait_grant(1'b1, 8'h03, code);
    check("t4_first", code, 0);
    for (int i = 0; i < MAX_HOLD - 1; i++) cycle(1'b0, 1'b1, 8'h03, 1'b0);
    check("t4_still_v", o_grant_v, 1'b1);
    cycle(1'b0, 1'b1, 8'h03, 1'b0);
    check("t4_pulse", o_timeout, 1'b1);
    wait_grant(1'b1, 8'h03, code);
    check("t4_next", code, 1);

    // Request drop and stray release
    do_reset();
    wait_grant(1'b0, 8'h08, code);
    check("t5_first", code, 3);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("t5_drop_v", o_grant_v, 1'b0);
    check("t5_no_tmo", o_timeout, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("t5_stray", o_grant_v, 1'b0);
    wait_grant(1'b0, 8'h08, code);
    check("t5_regrant", code, 3);

    // Reset mid-grant clears outputs and the rotation pointer
    do_reset();
    wait_grant(1'b1, 8'h20, code);
    check("t6_first", code, 5);
    cycle(1'b1, 1'b1, 8'h20, 1'b0);
    check("t6_rst_v", o_grant_v, 1'b0);
    check("t6_rst_code", o_grant_code, 3'd0);
    wait_grant(1'b1, 8'h21, code);
    check("t6_ptr0", code, 0);
    do_reset();
    wait_grant(1'b0, 8'h20, code);
    check("t6_again", code, 5);

    // Randomized traffic against the model
    rq = 8'h00;
    rm = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 7) == 0) rm = 1'($urandom);
      cycle($urandom_range(0, 99) == 0, rm, rq, $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
